// File: rtl/stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch
// Description : Elapsed-time measurer. Counts from a start pulse until a stop
//               pulse (or until the counters saturate) and presents a frozen
//               result in seconds + milliseconds with a one-cycle done strobe.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CYCLES_PER_MS  clock cycles per millisecond (2..65535)
//   SEC_W          width of the seconds field
// Ports
//   clock_i        system clock, rising edge
//   reset_i        asynchronous active-high reset
//   start_i        begin a new measurement (highest priority, any state)
//   stop_i         end the measurement (acted on only in RUN)
//   clear_i        return to IDLE and zero the result
//   running_o      high while measuring
//   done_o         one-cycle strobe when a result freezes
//   overflow_o     sticky: the measurement saturated
//   ms_count_o     millisecond field, 0..999
//   sec_count_o    seconds field
// ============================================================================
module stopwatch #(
  parameter int unsigned CYCLES_PER_MS = 50000,
  parameter int unsigned SEC_W         = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  output logic             running_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [9:0]       ms_count_o,
  output logic [SEC_W-1:0] sec_count_o
);

  localparam int unsigned          c_PRESC_W   = $clog2(CYCLES_PER_MS);
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CYCLES_PER_MS - 1);
  localparam logic [9:0]           c_MS_MAX    = 10'd999;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_RUN  = 2'd1;
  localparam logic [1:0] c_S_HOLD = 2'd2;

  logic [1:0]           state_q,  state_d;
  logic [c_PRESC_W-1:0] presc_q,  presc_d;
  logic [9:0]           ms_q,     ms_d;
  logic [SEC_W-1:0]     sec_q,    sec_d;
  logic                 ovf_q,    ovf_d;
  logic                 done_q,   done_d;

  logic w_presc_wrap;
  logic w_ms_wrap;
  logic w_sec_full;

  assign w_presc_wrap = (presc_q == c_PRESC_MAX);
  assign w_ms_wrap    = (ms_q == c_MS_MAX);
  assign w_sec_full   = &sec_q;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= c_S_IDLE;
      presc_q <= '0;
      ms_q    <= '0;
      sec_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      sec_q   <= sec_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Priority: start > clear > stop > advance.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    sec_d   = sec_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    if (start_i) begin
      state_d = c_S_RUN;
      presc_d = '0;
      ms_d    = '0;
      sec_d   = '0;
      ovf_d   = 1'b0;
    end else if (clear_i) begin
      state_d = c_S_IDLE;
      presc_d = '0;
      ms_d    = '0;
      sec_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == c_S_RUN) begin
      if (stop_i) begin
        // Freeze without advancing on this cycle.
        state_d = c_S_HOLD;
        done_d  = 1'b1;
      end else if (w_presc_wrap && w_ms_wrap && w_sec_full) begin
        // Next advance would wrap the whole result: saturate instead.
        state_d = c_S_HOLD;
        ovf_d   = 1'b1;
        done_d  = 1'b1;
      end else if (w_presc_wrap) begin
        presc_d = '0;
        if (w_ms_wrap) begin
          ms_d  = '0;
          sec_d = sec_q + SEC_W'(1);
        end else begin
          ms_d  = ms_q + 10'd1;
        end
      end else begin
        presc_d = presc_q + c_PRESC_W'(1);
      end
    end else if (state_q != c_S_IDLE && state_q != c_S_HOLD) begin
      // Unused encoding: recover to IDLE.
      state_d = c_S_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registers only, so no input-to-output path.
  // --------------------------------------------------------------------------
  always_comb begin
    running_o   = (state_q == c_S_RUN);
    done_o      = done_q;
    overflow_o  = ovf_q;
    ms_count_o  = ms_q;
    sec_count_o = sec_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch
// Description : Self-checking bench for stopwatch. A reference model tracks
//               the measurement as a plain count of advances and derives the
//               expected seconds/milliseconds arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch;

  localparam int unsigned CYCLES_PER_MS = 4;
  localparam int unsigned SEC_W         = 2;
  // Largest representable result in ms, and the advance count that saturates.
  localparam int c_MAX_MS   = (1 << SEC_W) * 1000 - 1;
  localparam int c_SAT_ADV  = (1 << SEC_W) * 1000 * CYCLES_PER_MS;

  localparam int c_M_IDLE = 0;
  localparam int c_M_RUN  = 1;
  localparam int c_M_HOLD = 2;

  logic             clock_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             start_i = 1'b0;
  logic             stop_i  = 1'b0;
  logic             clear_i = 1'b0;
  logic             running_o;
  logic             done_o;
  logic             overflow_o;
  logic [9:0]       ms_count_o;
  logic [SEC_W-1:0] sec_count_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_mode = c_M_IDLE;
  int m_adv  = 0;
  bit m_ovf  = 1'b0;
  bit m_done = 1'b0;

  stopwatch #(
    .CYCLES_PER_MS (CYCLES_PER_MS),
    .SEC_W         (SEC_W)
  ) u_dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .clear_i     (clear_i),
    .running_o   (running_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o),
    .ms_count_o  (ms_count_o),
    .sec_count_o (sec_count_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_total_ms();
    int t;
    t = m_adv / CYCLES_PER_MS;
    if (t > c_MAX_MS) t = c_MAX_MS;
    return t;
  endfunction

  task automatic model_reset();
    m_mode = c_M_IDLE;
    m_adv  = 0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit cl);
    m_done = 1'b0;
    if (st) begin
      m_mode = c_M_RUN; m_adv = 0; m_ovf = 1'b0;
    end else if (cl) begin
      m_mode = c_M_IDLE; m_adv = 0; m_ovf = 1'b0;
    end else if (m_mode == c_M_RUN) begin
      if (sp) begin
        m_mode = c_M_HOLD; m_done = 1'b1;
      end else begin
        m_adv++;
        if (m_adv >= c_SAT_ADV) begin
          m_mode = c_M_HOLD; m_ovf = 1'b1; m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    int t;
    t = exp_total_ms();
    check({tag, ".running"},  64'(running_o),   64'(m_mode == c_M_RUN));
    check({tag, ".done"},     64'(done_o),      64'(m_done));
    check({tag, ".overflow"}, 64'(overflow_o),  64'(m_ovf));
    check({tag, ".ms"},       64'(ms_count_o),  64'(t % 1000));
    check({tag, ".sec"},      64'(sec_count_o), 64'(t / 1000));
  endtask

  // Drive one cycle of inputs, clock it, then check all outputs 1 time unit on.
  task automatic step(input bit st, input bit sp, input bit cl, input string tag);
    start_i = st; stop_i = sp; clear_i = cl;
    @(posedge clock_i);
    model_edge(st, sp, cl);
    #1;
    compare_all(tag);
    start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
  endtask

  initial begin
    int cyc;

    // ---------------- reset ----------------
    model_reset();
    repeat (2) @(posedge clock_i);
    #1;
    compare_all("reset");
    reset_i = 1'b0;
    step(0, 1, 0, "idle_stop");

    // ---------------- basic measurement: stop at t+13 ----------------
    step(1, 0, 0, "basic_start");
    check("basic_running_t1", 64'(running_o), 64'd1);
    repeat (12) step(0, 0, 0, "basic_run");
    step(0, 1, 0, "basic_stop");
    check("basic_ms", 64'(ms_count_o), 64'd3);
    check("basic_done", 64'(done_o), 64'd1);
    step(0, 0, 0, "basic_after");
    check("basic_done_once", 64'(done_o), 64'd0);
    check("basic_running_low", 64'(running_o), 64'd0);

    // ---------------- millisecond wrap: stop 4009 edges later ----------------
    step(1, 0, 0, "wrap_start");
    repeat (4008) step(0, 0, 0, "wrap_run");
    step(0, 1, 0, "wrap_stop");
    check("wrap_sec", 64'(sec_count_o), 64'd1);
    check("wrap_ms",  64'(ms_count_o),  64'd2);

    // ---------------- stop in HOLD changes nothing ----------------
    step(0, 1, 0, "hold_stop");
    check("hold_stop_ms", 64'(ms_count_o), 64'd2);

    // ---------------- restart from HOLD ----------------
    step(1, 0, 0, "restart");
    check("restart_ms0", 64'(ms_count_o), 64'd0);
    check("restart_run", 64'(running_o), 64'd1);
    repeat (8) step(0, 0, 0, "restart_run");
    step(0, 1, 0, "restart_stop");
    check("restart_ms", 64'(ms_count_o), 64'd2);

    // ---------------- start + stop together in RUN ----------------
    step(1, 0, 0, "ss_start");
    repeat (9) step(0, 0, 0, "ss_run");
    step(1, 1, 0, "ss_both");
    check("ss_no_done", 64'(done_o), 64'd0);
    check("ss_running", 64'(running_o), 64'd1);

    // ---------------- clear + stop together in RUN ----------------
    repeat (6) step(0, 0, 0, "cs_run");
    step(0, 1, 1, "cs_both");
    check("cs_no_done", 64'(done_o), 64'd0);
    check("cs_idle", 64'(running_o), 64'd0);
    step(0, 0, 1, "clear_idle");

    // ---------------- saturation ----------------
    step(1, 0, 0, "sat_start");
    for (int i = 1; i < c_SAT_ADV; i++) step(0, 0, 0, "sat_run");
    step(0, 0, 0, "sat_edge");
    check("sat_ovf",  64'(overflow_o),  64'd1);
    check("sat_sec",  64'(sec_count_o), 64'd3);
    check("sat_ms",   64'(ms_count_o),  64'd999);
    check("sat_done", 64'(done_o),      64'd1);
    repeat (100) step(0, 0, 0, "sat_hold");
    check("sat_hold_ms", 64'(ms_count_o), 64'd999);

    // ---------------- async reset mid-RUN ----------------
    step(1, 0, 0, "ar_start");
    repeat (10) step(0, 0, 0, "ar_run");
    #2 reset_i = 1'b1;
    #1;
    model_reset();
    compare_all("async_reset");
    #1 reset_i = 1'b0;
    repeat (5) step(0, 1, 0, "ar_idle");

    // ---------------- randomized stimulus ----------------
    for (cyc = 0; cyc < 6000; cyc++) begin
      bit st, sp, cl;
      st = ($urandom_range(0, 299) == 0);
      sp = ($urandom_range(0, 149) == 0);
      cl = ($urandom_range(0, 499) == 0);
      step(st, sp, cl, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
